// File: rtl/paint_grid_ctrl.sv
// Keypad-driven colour-painting controller: scans a GRID x GRID keypad with a
// debounced single-key scanner, paints the selected cell and flags a full-grid match.
module paint_grid_ctrl #(
   parameter int GRID     = 4,
   parameter int COLOR_W  = 3,
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8,
   localparam int CELLS   = GRID * GRID,
   localparam int IDX_W   = $clog2(CELLS),
   localparam int ROW_W   = $clog2(GRID),
   localparam int DIV_W   = $clog2(SCAN_DIV),
   localparam int DB_W    = $clog2(DEBOUNCE + 1)
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [COLOR_W-1:0]         color,
   input  logic [COLOR_W-1:0]         color1,
   input  logic [COLOR_W-1:0]         color2,
   input  logic [CELLS-1:0]           target_mask,
   input  logic                       clear,
   input  logic [GRID-1:0]            C,
   output logic [GRID-1:0]            R,
   output logic [CELLS*COLOR_W-1:0]   paper,
   output logic                       key_valid,
   output logic [IDX_W-1:0]           key_idx,
   output logic [CNT_W-1:0]           paint_count,
   output logic                       correct
);

   typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_e;

   state_e                     state_q, state_d;
   logic [DIV_W-1:0]           div_q, div_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [IDX_W-1:0]           cand_q, cand_d;
   logic [ROW_W-1:0]           cand_row_q, cand_row_d;
   logic [ROW_W-1:0]           cand_col_q, cand_col_d;
   logic [DB_W-1:0]            cnt_q, cnt_d;
   logic                       key_valid_q, key_valid_d;
   logic [IDX_W-1:0]           key_idx_q, key_idx_d;
   logic [CELLS*COLOR_W-1:0]   paper_q, paper_d;
   logic [CNT_W-1:0]           paint_count_q, paint_count_d;
   logic                       correct_q, correct_d;

   logic                       tick;
   logic [ROW_W:0]             low_cnt;
   logic [ROW_W-1:0]           hit_col;
   logic                       hit;
   logic [IDX_W-1:0]           hit_idx;
   logic                       on_cand_row;
   logic                       cand_present;
   logic                       new_press;
   logic [CELLS*COLOR_W-1:0]   target;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= S_IDLE;
         div_q         <= '0;
         row_q         <= '0;
         cand_q        <= '0;
         cand_row_q    <= '0;
         cand_col_q    <= '0;
         cnt_q         <= '0;
         key_valid_q   <= 1'b0;
         key_idx_q     <= '0;
         paper_q       <= '0;
         paint_count_q <= '0;
         correct_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         row_q         <= row_d;
         cand_q        <= cand_d;
         cand_row_q    <= cand_row_d;
         cand_col_q    <= cand_col_d;
         cnt_q         <= cnt_d;
         key_valid_q   <= key_valid_d;
         key_idx_q     <= key_idx_d;
         paper_q       <= paper_d;
         paint_count_q <= paint_count_d;
         correct_q     <= correct_d;
      end
   end

   always_comb begin
      tick  = (div_q == DIV_W'(SCAN_DIV - 1));
      div_d = tick ? '0 : div_q + 1'b1;
      row_d = row_q;
      if (tick) begin
         row_d = (row_q == ROW_W'(GRID - 1)) ? '0 : row_q + 1'b1;
      end
   end

   // More than one low column in a row is a ghost pattern and decodes as no key.
   always_comb begin
      low_cnt = '0;
      hit_col = '0;
      for (int c = 0; c < GRID; c++) begin
         if (!C[c]) begin
            low_cnt = low_cnt + 1'b1;
            hit_col = ROW_W'(c);
         end
      end
      hit          = (low_cnt == (ROW_W + 1)'(1));
      hit_idx      = IDX_W'(row_q) * IDX_W'(GRID) + IDX_W'(hit_col);
      on_cand_row  = (row_q == cand_row_q);
      cand_present = !C[cand_col_q];
   end

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      cand_row_d = cand_row_q;
      cand_col_d = cand_col_q;
      cnt_d      = cnt_q;
      if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (hit) begin
                  cand_d     = hit_idx;
                  cand_row_d = row_q;
                  cand_col_d = hit_col;
                  cnt_d      = DB_W'(1);
                  state_d    = (DEBOUNCE == 1) ? S_HELD : S_CONFIRM;
               end
            end
            S_CONFIRM: begin
               if (on_cand_row) begin
                  if (hit && (hit_idx == cand_q)) begin
                     cnt_d = cnt_q + 1'b1;
                     if (cnt_q + 1'b1 == DB_W'(DEBOUNCE)) state_d = S_HELD;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_HELD: begin
               if (on_cand_row && !cand_present) begin
                  cnt_d   = DB_W'(1);
                  state_d = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (on_cand_row) begin
                  if (cand_present) begin
                     state_d = S_HELD;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                     if (cnt_q + 1'b1 == DB_W'(DEBOUNCE)) state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Only a fresh press counts; a bounce back from RELEASE to HELD is the same key.
   always_comb begin
      new_press     = tick && (state_d == S_HELD) &&
                      ((state_q == S_IDLE) || (state_q == S_CONFIRM));
      key_valid_d   = new_press;
      key_idx_d     = new_press ? cand_d : key_idx_q;
      paper_d       = paper_q;
      paint_count_d = paint_count_q;
      if (clear) begin
         paper_d       = '0;
         paint_count_d = '0;
      end else if (new_press) begin
         paper_d[cand_d*COLOR_W +: COLOR_W] = color;
         if (paint_count_q != '1) paint_count_d = paint_count_q + 1'b1;
      end
      for (int k = 0; k < CELLS; k++) begin
         target[k*COLOR_W +: COLOR_W] = target_mask[k] ? color1 : color2;
      end
      correct_d = (paper_q == target);
   end

   assign R           = ~(GRID'(1) << row_q);
   assign paper       = paper_q;
   assign key_valid   = key_valid_q;
   assign key_idx     = key_idx_q;
   assign paint_count = paint_count_q;
   assign correct     = correct_q;

endmodule

// File: tb/tb_paint_grid_ctrl.sv
// Self-checking bench for paint_grid_ctrl: a keypad model drives C from R and a
// scan-level reference model predicts presses, paper, counters and the match flag.
module tb_paint_grid_ctrl;
   localparam int G     = 4;
   localparam int CW    = 3;
   localparam int SD    = 4;
   localparam int DB    = 3;
   localparam int CELLS = G * G;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CW-1:0]     color, color1, color2;
   logic [CELLS-1:0]  target_mask;
   logic              clear;
   logic [G-1:0]      c_a, r_a, c_b, r_b;
   logic [CELLS*CW-1:0] paper_a, paper_b;
   logic              kv_a, kv_b, corr_a, corr_b;
   logic [3:0]        kidx_a, kidx_b;
   logic [7:0]        pc_a;
   logic [1:0]        pc_b;

   logic              key_down;
   logic              ghost;
   int                key_sel;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   int            m_cyc, m_run, m_rel, m_cnt, m_cnt2, m_kidx;
   bit            m_locked, m_kv, m_corr;
   logic [CW-1:0] m_paper [CELLS];

   always #5 clk = ~clk;

   paint_grid_ctrl #(.GRID(G), .COLOR_W(CW), .SCAN_DIV(SD), .DEBOUNCE(DB), .CNT_W(8)) dut_a (
      .Clk(clk), .Rst_n(rst_n), .color(color), .color1(color1), .color2(color2),
      .target_mask(target_mask), .clear(clear), .C(c_a), .R(r_a), .paper(paper_a),
      .key_valid(kv_a), .key_idx(kidx_a), .paint_count(pc_a), .correct(corr_a));

   paint_grid_ctrl #(.GRID(G), .COLOR_W(CW), .SCAN_DIV(SD), .DEBOUNCE(DB), .CNT_W(2)) dut_b (
      .Clk(clk), .Rst_n(rst_n), .color(color), .color1(color1), .color2(color2),
      .target_mask(target_mask), .clear(clear), .C(c_b), .R(r_b), .paper(paper_b),
      .key_valid(kv_b), .key_idx(kidx_b), .paint_count(pc_b), .correct(corr_b));

   // A pressed key pulls its column low only while its row is driven.
   always_comb begin
      c_a = '1;
      c_b = '1;
      if (ghost) begin
         c_a = 4'b1001;
         c_b = 4'b1001;
      end else if (key_down) begin
         if (!r_a[key_sel / G]) c_a[key_sel % G] = 1'b0;
         if (!r_b[key_sel / G]) c_b[key_sel % G] = 1'b0;
      end
   end

   task automatic model_reset();
      m_cyc = 0; m_run = 0; m_rel = 0; m_locked = 0;
      m_cnt = 0; m_cnt2 = 0; m_kv = 0; m_kidx = 0; m_corr = 0;
      for (int k = 0; k < CELLS; k++) m_paper[k] = '0;
   endtask

   function automatic bit will_accept();
      return (m_cyc % SD == SD - 1) && !m_locked && (m_run == DB - 1) &&
             ((m_cyc / SD) % G == key_sel / G) && key_down && !ghost;
   endfunction

   function automatic logic [63:0] model_vec();
      logic [CELLS*CW-1:0] flat;
      for (int k = 0; k < CELLS; k++) flat[k*CW +: CW] = m_paper[k];
      return {m_kv, 4'(m_kidx), 8'(m_cnt), 2'(m_cnt2), m_corr, flat};
   endfunction

   function automatic logic [63:0] dut_vec();
      return {kv_a, kidx_a, pc_a, pc_b, corr_a, paper_a};
   endfunction

   // One clock: the model consumes the inputs present at the rising edge.
   task automatic step();
      bit tick, present, acc, match;
      int row;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         tick    = (m_cyc % SD) == SD - 1;
         row     = (m_cyc / SD) % G;
         present = key_down && !ghost && (key_sel / G == row);
         match   = 1;
         for (int k = 0; k < CELLS; k++)
            if (m_paper[k] != (target_mask[k] ? color1 : color2)) match = 0;
         m_corr = match;
         acc = 0;
         if (tick && row == key_sel / G) begin
            if (!m_locked) begin
               m_run = present ? m_run + 1 : 0;
               if (m_run == DB) begin acc = 1; m_locked = 1; m_rel = 0; end
            end else begin
               m_rel = present ? 0 : m_rel + 1;
               if (m_rel == DB) begin m_locked = 0; m_run = 0; end
            end
         end
         m_kv = acc;
         if (acc) m_kidx = key_sel;
         if (clear) begin
            for (int k = 0; k < CELLS; k++) m_paper[k] = '0;
            m_cnt = 0; m_cnt2 = 0;
         end else if (acc) begin
            m_paper[key_sel] = color;
            m_cnt  = (m_cnt  == 255) ? 255 : m_cnt + 1;
            m_cnt2 = (m_cnt2 == 3)   ? 3   : m_cnt2 + 1;
         end
         m_cyc++;
      end
      @(negedge clk);
   endtask

   task automatic drive_cycles(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         step();
         if (kv_a === 1'b1) pulses++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, m_cyc, dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_r;
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if (dut_vec() !== 64'd0) begin
         errors++; $display("[TB] FAIL reset_outputs got=%h exp=%h", dut_vec(), 64'd0);
      end
      checks++;
      if (r_a !== 4'b1110) begin
         errors++; $display("[TB] FAIL reset_R got=%b exp=1110", r_a);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         exp_r = ~(4'b0001 << ((m_cyc / SD) % G));
         checks++;
         if (r_a !== exp_r) begin
            errors++; $display("[TB] FAIL row_scan cyc=%0d got=%b exp=%b", m_cyc, r_a, exp_r);
         end
      end
   endtask

   task automatic test_single_press();
      key_sel = 9; color = 3'b101; key_down = 1'b1; pulses = 0;
      drive_cycles(80, "press_hold");
      checks++;
      if (pulses !== 1) begin errors++; $display("[TB] FAIL press_pulses got=%0d exp=1", pulses); end
      checks++;
      if (kidx_a !== 4'd9) begin errors++; $display("[TB] FAIL press_idx got=%0d exp=9", kidx_a); end
      checks++;
      if (paper_a[27 +: 3] !== 3'b101) begin
         errors++; $display("[TB] FAIL press_cell got=%b exp=101", paper_a[27 +: 3]);
      end
      checks++;
      if (pc_a !== 8'd1) begin errors++; $display("[TB] FAIL press_count got=%0d exp=1", pc_a); end
      drive_cycles(100, "press_still_held");
      checks++;
      if (pulses !== 1) begin errors++; $display("[TB] FAIL no_repeat got=%0d exp=1", pulses); end
      key_down = 1'b0;
      drive_cycles(100, "press_release");
   endtask

   task automatic test_bounce();
      int n = 0;
      key_sel = 5; color = 3'b011; key_down = 1'b1; pulses = 0;
      while (m_run < 2 && n < 100) begin drive_cycles(1, "bounce_on"); n++; end
      if (n == 100) begin
         checks++; errors++; $display("[TB] FAIL bounce_wait got=timeout exp=2 samples");
      end
      key_down = 1'b0;
      drive_cycles(100, "bounce_off");
      checks++;
      if (pulses !== 0) begin errors++; $display("[TB] FAIL bounce_pulses got=%0d exp=0", pulses); end
   endtask

   task automatic test_ghost();
      pulses = 0; ghost = 1'b1; color = 3'b111;
      drive_cycles(150, "ghost");
      ghost = 1'b0;
      drive_cycles(20, "ghost_after");
      checks++;
      if (pulses !== 0) begin errors++; $display("[TB] FAIL ghost_pulses got=%0d exp=0", pulses); end
   endtask

   task automatic test_paint_all();
      target_mask = 16'h0660; color1 = 3'b100; color2 = 3'b001;
      clear = 1'b1; drive_cycles(1, "paint_clear"); clear = 1'b0;
      for (int k = 0; k < CELLS; k++) begin
         key_sel = k; color = target_mask[k] ? color1 : color2; key_down = 1'b1;
         drive_cycles(70, "paint_hold");
         key_down = 1'b0;
         drive_cycles(90, "paint_gap");
      end
      checks++;
      if (corr_a !== 1'b1) begin errors++; $display("[TB] FAIL paint_correct got=%b exp=1", corr_a); end
      color1 = 3'b010;
      drive_cycles(1, "paint_recolour");
      checks++;
      if (corr_a !== 1'b0) begin errors++; $display("[TB] FAIL paint_correct_fall got=%b exp=0", corr_a); end
      drive_cycles(5, "paint_settle");
   endtask

   task automatic test_clear_same_cycle();
      int n = 0;
      key_sel = int'($urandom_range(0, 15)); color = 3'($urandom_range(1, 7)); key_down = 1'b1;
      while (!will_accept() && n < 100) begin drive_cycles(1, "clr_wait"); n++; end
      if (n == 100) begin
         checks++; errors++; $display("[TB] FAIL clr_wait got=timeout exp=accept");
      end
      clear = 1'b1;
      drive_cycles(1, "clr_press");
      clear = 1'b0;
      checks++;
      if (kv_a !== 1'b1) begin errors++; $display("[TB] FAIL clr_key_valid got=%b exp=1", kv_a); end
      checks++;
      if (paper_a !== '0) begin errors++; $display("[TB] FAIL clr_paper got=%h exp=0", paper_a); end
      checks++;
      if (pc_a !== 8'd0) begin errors++; $display("[TB] FAIL clr_count got=%0d exp=0", pc_a); end
      checks++;
      if (kidx_a !== 4'(key_sel)) begin
         errors++; $display("[TB] FAIL clr_idx got=%0d exp=%0d", kidx_a, key_sel);
      end
      drive_cycles(30, "clr_hold");
      key_down = 1'b0;
      drive_cycles(100, "clr_release");
   endtask

   task automatic test_reset_mid_press();
      int n = 0;
      key_sel = 6; color = 3'b110; key_down = 1'b1;
      while (m_run < 1 && n < 100) begin drive_cycles(1, "rst_wait"); n++; end
      if (n == 100) begin
         checks++; errors++; $display("[TB] FAIL rst_wait got=timeout exp=confirm");
      end
      drive_cycles(3, "rst_confirm");
      rst_n = 1'b0;
      #1;
      checks++;
      if ({kv_a, kidx_a, pc_a, pc_b, corr_a, paper_a} !== 64'd0) begin
         errors++; $display("[TB] FAIL rst_async got=%h exp=0", dut_vec());
      end
      checks++;
      if (r_a !== 4'b1110) begin errors++; $display("[TB] FAIL rst_async_R got=%b exp=1110", r_a); end
      step(); step();
      rst_n = 1'b1;
      pulses = 0;
      drive_cycles(100, "rst_repress");
      checks++;
      if (pulses !== 1) begin errors++; $display("[TB] FAIL rst_repress_pulses got=%0d exp=1", pulses); end
      key_down = 1'b0;
      drive_cycles(100, "rst_release");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         key_sel = int'($urandom_range(0, 15));
         color   = 3'($urandom_range(0, 7));
         color2  = 3'($urandom_range(0, 7));
         key_down = 1'b1;
         drive_cycles(int'($urandom_range(60, 90)), "rand_hold");
         key_down = 1'b0;
         drive_cycles(int'($urandom_range(80, 110)), "rand_gap");
      end
   endtask

   task automatic test_saturation();
      clear = 1'b1; drive_cycles(1, "sat_clear"); clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         key_sel = (i * 3) % CELLS; color = 3'(i + 1); key_down = 1'b1;
         drive_cycles(70, "sat_hold");
         key_down = 1'b0;
         drive_cycles(90, "sat_gap");
      end
      checks++;
      if (pc_b !== 2'd3) begin errors++; $display("[TB] FAIL sat_count2 got=%0d exp=3", pc_b); end
      checks++;
      if (pc_a !== 8'd5) begin errors++; $display("[TB] FAIL sat_count8 got=%0d exp=5", pc_a); end
   endtask

   initial begin
      rst_n = 1'b0; color = '0; color1 = '0; color2 = '0; target_mask = '0;
      clear = 1'b0; key_down = 1'b0; ghost = 1'b0; key_sel = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_press();
      test_bounce();
      test_ghost();
      test_paint_all();
      test_clear_same_cycle();
      test_reset_mid_press();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
